// File: rtl/fft_tile_sched.sv
// Tile scheduler feeding a 2D-FFT engine from image memory and writing results back in order.
// Optional FFT_SCHED_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module fft_tile_sched #(
    parameter int ADDR_WIDTH   = 13,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH-1:0] tile_count,
    output logic [ADDR_WIDTH-1:0] img_read_address,
    output logic                  fft_next,
    input  logic                  fft_next_out,
    output logic                  res_we,
    output logic [ADDR_WIDTH-1:0] res_write_address,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
`ifdef FFT_SCHED_PERF_EN
    output logic [31:0]           perf_cycles,
`endif
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2, S_FINISH = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, dst_q, count_q;
    logic [ADDR_WIDTH-1:0] issued_q, returned_q, raddr_q;
    logic [3:0]            inflight_q;
    logic                  fft_next_q, err_q;
    logic                  start_ok, issue, accept, proto_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ISSUE;
            S_ISSUE:  if (issued_q == count_q) state_d = S_DRAIN;
            S_DRAIN:  if (returned_q == count_q) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // A result is only legal while a job is running and at least one tile is outstanding.
    always_comb begin
        busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done      = (state_q == S_FINISH);
        start_ok  = (state_q == S_IDLE) && start;
        issue     = (state_q == S_ISSUE) && (issued_q < count_q)
                    && (inflight_q < 4'(MAX_INFLIGHT));
        accept    = fft_next_out && busy && (inflight_q != 4'd0);
        proto_err = fft_next_out && !accept;
        img_read_address  = issue ? (src_q + issued_q) : raddr_q;
        res_we            = accept;
        res_write_address = dst_q + returned_q;
        fft_next          = fft_next_q;
        err               = err_q;
        dbg_state_o       = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q      <= '0;
            dst_q      <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            inflight_q <= '0;
            raddr_q    <= '0;
            fft_next_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            raddr_q    <= img_read_address;
            fft_next_q <= issue;
            err_q      <= err_q | proto_err;
            if (start_ok) begin
                src_q      <= src_base;
                dst_q      <= dst_base;
                count_q    <= tile_count;
                issued_q   <= '0;
                returned_q <= '0;
                inflight_q <= '0;
            end else begin
                if (issue)  issued_q   <= issued_q + 1'b1;
                if (accept) returned_q <= returned_q + 1'b1;
                if (issue && !accept)      inflight_q <= inflight_q + 4'd1;
                else if (accept && !issue) inflight_q <= inflight_q - 4'd1;
            end
        end
    end

`ifdef FFT_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            perf_q <= '0;
        else if (start_ok)                    perf_q <= '0;
        else if (busy && (perf_q != '1))      perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_fft_tile_sched.sv
// Self-checking bench for fft_tile_sched: a default instance (4 in flight) and a 2-in-flight instance,
// each fed by a fixed-latency engine model; expected timing comes from a closed-form issue schedule.
module tb_fft_tile_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b, fno_a, fno_b;
    logic [12:0] src, dst, cnt;
    logic [12:0] addr_a, addr_b, waddr_a, waddr_b;
    logic        fn_a, fn_b, we_a, we_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [1:0]  st_a, st_b;
`ifdef FFT_SCHED_PERF_EN
    logic [31:0] perf_a, perf_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] o_addr, o_waddr;
    logic        o_fn, o_we, o_busy, o_done, o_err;

    always #5 clk = ~clk;

    fft_tile_sched #(.ADDR_WIDTH(13), .MAX_INFLIGHT(4)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .src_base(src), .dst_base(dst),
        .tile_count(cnt), .img_read_address(addr_a), .fft_next(fn_a), .fft_next_out(fno_a),
        .res_we(we_a), .res_write_address(waddr_a), .busy(busy_a), .done(done_a), .err(err_a),
`ifdef FFT_SCHED_PERF_EN
        .perf_cycles(perf_a),
`endif
        .dbg_state_o(st_a));

    fft_tile_sched #(.ADDR_WIDTH(13), .MAX_INFLIGHT(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .src_base(src), .dst_base(dst),
        .tile_count(cnt), .img_read_address(addr_b), .fft_next(fn_b), .fft_next_out(fno_b),
        .res_we(we_b), .res_write_address(waddr_b), .busy(busy_b), .done(done_b), .err(err_b),
`ifdef FFT_SCHED_PERF_EN
        .perf_cycles(perf_b),
`endif
        .dbg_state_o(st_b));

    typedef struct {
        int          sel;
        logic [12:0] s;
        logic [12:0] d;
        logic [12:0] n;
        int          lat;
        int          exp_done;
        int          restart;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            o_addr = addr_a; o_waddr = waddr_a; o_fn = fn_a; o_we = we_a;
            o_busy = busy_a; o_done = done_a; o_err = err_a;
        end else begin
            o_addr = addr_b; o_waddr = waddr_b; o_fn = fn_b; o_we = we_b;
            o_busy = busy_b; o_done = done_b; o_err = err_b;
        end
    endtask

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    // Read k may start only one cycle after tile k-M has returned; returns land L cycles after fft_next.
    task automatic run_job(input int sel, input logic [12:0] s, input logic [12:0] d,
                           input logic [12:0] n, input int lat, input int exp_done_in,
                           input int restart, input string name);
        int r[64];
        int ret_q[$];
        int m, exp_done, rd_k, wr_k, outstanding, n_we;
        logic prev_read, exp_read, due;
        logic [12:0] ea;
        m = (sel == 0) ? 4 : 2;
        for (int k = 0; k < int'(n); k++) begin
            r[k] = (k == 0) ? 1 : r[k-1] + 1;
            if (k >= m && r[k-m] + lat + 2 > r[k]) r[k] = r[k-m] + lat + 2;
        end
        exp_done = (exp_done_in >= 0) ? exp_done_in : ((n == 0) ? 3 : r[int'(n)-1] + lat + 3);
        rd_k = 0; wr_k = 0; outstanding = 0; n_we = 0; prev_read = 1'b0;
        @(negedge clk);
        src = s; dst = d; cnt = n;
        drive_start(sel, 1'b1);
        for (int c = 1; c <= exp_done + 2; c++) begin
            @(negedge clk);
            drive_start(sel, c == restart);
            if (c == restart) cnt = 13'd5;
            due = (ret_q.size() > 0) && (ret_q[0] == c);
            if (due) void'(ret_q.pop_front());
            if (sel == 0) fno_a = due; else fno_b = due;
            #1;
            sample(sel);
            exp_read = (rd_k < int'(n)) && (r[rd_k] == c);
            if (exp_read) begin
                ea = s + 13'(rd_k);
                check({name, " read_addr"}, 32'(o_addr), 32'(ea));
                rd_k++;
            end
            check({name, " fft_next"}, 32'(o_fn), 32'(prev_read));
            if (o_fn) begin
                ret_q.push_back(c + lat);
                outstanding++;
            end
            check({name, " res_we"}, 32'(o_we), 32'(due));
            if (o_we) n_we++;
            if (due) begin
                ea = d + 13'(wr_k);
                check({name, " write_addr"}, 32'(o_waddr), 32'(ea));
                wr_k++;
                outstanding--;
            end
            if (outstanding > m) check({name, " inflight_limit"}, 32'(outstanding), 32'(m));
            check({name, " busy"}, 32'(o_busy), 32'(c < exp_done));
            check({name, " done"}, 32'(o_done), 32'(c == exp_done));
            prev_read = exp_read;
        end
        fno_a = 1'b0; fno_b = 1'b0;
        check({name, " write_count"}, 32'(n_we), 32'(n));
        check({name, " err"}, 32'(o_err), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; fno_a = 1'b0; fno_b = 1'b0;
        src = '0; dst = '0; cnt = '0;
        tbl[0] = '{sel: 0, s: 13'h0100, d: 13'h0200, n: 13'd3, lat: 5,  exp_done: 11, restart: -1};
        tbl[1] = '{sel: 1, s: 13'h0300, d: 13'h0400, n: 13'd6, lat: 10, exp_done: 39, restart: -1};
        tbl[2] = '{sel: 0, s: 13'h1FFE, d: 13'h0A00, n: 13'd4, lat: 3,  exp_done: 10, restart: -1};
        tbl[3] = '{sel: 0, s: 13'h0050, d: 13'h0060, n: 13'd0, lat: 4,  exp_done: 3,  restart: 2};
        tbl[4] = '{sel: 0, s: 13'h0040, d: 13'h0080, n: 13'd1, lat: 4,  exp_done: 8,  restart: -1};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sample(i);
            check("reset addr", 32'(o_addr), 32'd0);
            check("reset fft_next", 32'(o_fn), 32'd0);
            check("reset res_we", 32'(o_we), 32'd0);
            check("reset busy", 32'(o_busy), 32'd0);
            check("reset done", 32'(o_done), 32'd0);
            check("reset err", 32'(o_err), 32'd0);
        end
        check("reset state", 32'(st_a), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i].sel, tbl[i].s, tbl[i].d, tbl[i].n, tbl[i].lat, tbl[i].exp_done,
                    tbl[i].restart, $sformatf("vec%0d", i));
`ifdef FFT_SCHED_PERF_EN
            if (i == 4) begin
                check("perf_cycles", perf_a, 32'd7);
                @(negedge clk);
                check("perf_cycles hold", perf_a, 32'd7);
            end
`endif
        end

        for (int i = 0; i < 12; i++) begin
            run_job(int'($urandom_range(1, 0)), 13'($urandom), 13'($urandom),
                    13'($urandom_range(10, 1)), int'($urandom_range(12, 1)), -1, -1,
                    $sformatf("rand%0d", i));
        end

        // Result while a job is issuing but nothing is outstanding yet.
        @(negedge clk); src = 13'h10; dst = 13'h20; cnt = 13'd3; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; fno_a = 1'b1; #1;
        check("early result res_we", 32'(we_a), 32'd0);
        @(negedge clk); fno_a = 1'b0; #1;
        check("early result err", 32'(err_a), 32'd1);
        pulse_reset();
        #1;
        check("err cleared by reset", 32'(err_a), 32'd0);

        // Reset in DRAIN with two tiles outstanding, then a stray result.
        @(negedge clk); src = 13'h30; dst = 13'h40; cnt = 13'd2; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset drain busy", 32'(busy_a), 32'd1);
        reset = 1'b1; #1;
        check("mid reset busy", 32'(busy_a), 32'd0);
        check("mid reset addr", 32'(addr_a), 32'd0);
        check("mid reset fft_next", 32'(fn_a), 32'd0);
        check("mid reset state", 32'(st_a), 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); fno_a = 1'b1; #1;
        check("stray result res_we", 32'(we_a), 32'd0);
        @(negedge clk); fno_a = 1'b0; #1;
        check("stray result err", 32'(err_a), 32'd1);
        check("stray result idle", 32'(busy_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
